// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32 byte-addressed data memory with valid/ready handshake and wait states
// Optional: define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_mem_ctrl #(
    parameter int DWIDTH      = 32,
    parameter int MEMDEPTH    = 1024,
    parameter int AWIDTH      = $clog2(MEMDEPTH),
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [2:0]        req_func3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam int WS_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WS_LAST_V = WS_LAST[3:0];

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        func3_q;

    logic [DWIDTH-1:0] mem [MEMDEPTH];

    logic [AWIDTH-1:0] word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              illegal;
    logic              misaligned;
    logic              fault;
    logic [3:0]        byte_en;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    assign word_idx     = addr_q[AWIDTH+1:2];
    assign lane         = addr_q[1:0];
    assign out_of_range = (addr_q[31:AWIDTH+2] != '0);
    assign req_ready    = rst_n && (state == S_IDLE);
    assign resp_valid   = (state == S_RESP);
    assign rd_word      = mem[word_idx];

    always_comb begin
        illegal = 1'b0;
        if (we_q)
            illegal = !(func3_q == 3'd0 || func3_q == 3'd1 || func3_q == 3'd2);
        else
            illegal = !(func3_q == 3'd0 || func3_q == 3'd1 || func3_q == 3'd2 ||
                        func3_q == 3'd4 || func3_q == 3'd5);
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((func3_q[1:0] == 2'd1) && lane[0]) ||
                        ((func3_q[1:0] == 2'd2) && (lane != 2'd0));
`else
    assign misaligned = 1'b0;
`endif

    assign fault = out_of_range || illegal || misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = wdata_q;
        case (func3_q[1:0])
            2'd0: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                byte_en = 4'b1111;
                wr_word = wdata_q;
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (func3_q)
            3'd0: load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1: load_data = {{16{rd_half[15]}}, rd_half};
            3'd2: load_data = rd_word;
            3'd4: load_data = {24'd0, rd_byte};
            3'd5: load_data = {16'd0, rd_half};
            default: load_data = '0;
        endcase
    end

    // Gated by rst_n so a reset landing on the ACCESS edge cancels the store.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_ACCESS && we_q && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        func3_q  <= req_func3;
                        wait_cnt <= '0;
                        state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WS_LAST_V)
                        state <= S_ACCESS;
                    else
                        wait_cnt <= wait_cnt + 4'd1;
                end
                S_ACCESS: begin
                    resp_err   <= fault;
                    resp_rdata <= (fault || we_q) ? '0 : load_data;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (WAIT_STATES=3)
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    data_mem_ctrl #(
        .DWIDTH(32), .MEMDEPTH(1024), .WAIT_STATES(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] rd;
        logic        er;
        xact(1'b0, addr, 32'd0, f3, rd, er);
        check({tag, "_rdata"}, rd, exp_d);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3, input logic exp_e);
        logic [31:0] rd;
        logic        er;
        xact(1'b1, addr, wd, f3, rd, er);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_func3 = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        do_store("sw10", 32'h10, 32'hDEADBEEF, 3'd2, 1'b0);
        do_load("lw10", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        do_store("sb13", 32'h13, 32'h00000080, 3'd0, 1'b0);
        do_load("lb13", 32'h13, 3'd0, 32'hFFFFFF80, 1'b0);
        do_load("lbu13", 32'h13, 3'd4, 32'h00000080, 1'b0);
        do_load("lw10b", 32'h10, 3'd2, 32'h80ADBEEF, 1'b0);
        do_load("lh12", 32'h12, 3'd1, 32'hFFFF80AD, 1'b0);
        do_load("lhu12", 32'h12, 3'd5, 32'h000080AD, 1'b0);
        do_load("lbu11", 32'h11, 3'd4, 32'h000000BE, 1'b0);
        do_store("sw14", 32'h14, 32'h0, 3'd2, 1'b0);
        do_store("sh16", 32'h16, 32'h00001234, 3'd1, 1'b0);
        do_load("lw14", 32'h14, 3'd2, 32'h12340000, 1'b0);
        do_load("lh16", 32'h16, 3'd1, 32'h00001234, 1'b0);
`ifdef MISALIGN_TRAP_EN
        do_load("lw11", 32'h11, 3'd2, 32'h0, 1'b1);
`else
        do_load("lw11", 32'h11, 3'd2, 32'h80ADBEEF, 1'b0);
`endif
        do_store("sw0", 32'h0, 32'hCAFEF00D, 3'd2, 1'b0);
        do_store("sw_oor", 32'h1000, 32'h5, 3'd2, 1'b1);
        do_load("lw0", 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);
        do_load("ld_oor", 32'h1000, 3'd2, 32'h0, 1'b1);
        do_load("ld_f3_3", 32'h10, 3'd3, 32'h0, 1'b1);
        do_store("st_f3_4", 32'h0, 32'h0, 3'd4, 1'b1);
        do_load("lw0b", 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);

        // Latency and hold with resp_ready low: accept edge counts as edge 1.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'd2;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("lat_valid_e%0d", k), {31'd0, resp_valid}, {31'd0, k >= 5});
            check($sformatf("lat_ready_e%0d", k), {31'd0, req_ready}, 32'd0);
        end
        held = resp_rdata;
        check("held_rdata", held, 32'h80ADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'h80ADBEEF);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("released_valid", {31'd0, resp_valid}, 32'd0);

        // Reset pulsed during WAIT of a store: no response, word unchanged.
        do_store("sw20", 32'h20, 32'h11111111, 3'd2, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_func3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("drop_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        check("drop_ready", {31'd0, req_ready}, 32'd1);
        do_load("lw20", 32'h20, 3'd2, 32'h11111111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
